b01_line_tx: RTL and testbench

//   Serial-stream transmitter for the b01 comparator/adder datapath.
//   - Takes two parallel WIDTH-bit operands over a valid/ready handshake.
//   - Drives them LSB-first onto the line1/line2 serial pair.
//   - Samples the returned outp stream into a parallel result word, and accumulates the overflw flag.
//   - Sits between the block-level stimulus/scoreboard and the b01 line inputs.

---
 rtl/b01_line_tx_if.sv | 28 ++
 rtl/b01_line_tx.sv | 137 +++++++++++++
 tb/tb_b01_line_tx.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/b01_line_tx_if.sv
// Operand handshake, serial line pair and result bus of the b01 line transmitter.
// master = stimulus/scoreboard side, slave = b01_line_tx.
interface b01_line_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             line1;
  logic             line2;
  logic             outp;
  logic             overflw;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_ovf;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, outp, overflw,
    input  in_ready, line1, line2, res_valid, res_data, res_ovf, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, outp, overflw,
    output in_ready, line1, line2, res_valid, res_data, res_ovf, busy
  );
endinterface

// File: rtl/b01_line_tx.sv
// Serialises two operands LSB-first onto line1/line2 and captures the returned
// outp/overflw stream RSP_LAT cycles later into a parallel result word.
module b01_line_tx #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned RSP_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  b01_line_tx_if.slave  bus
);
  localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CAP_W = $clog2(WIDTH + RSP_LAT + 1);
  localparam int unsigned CMP_W = CAP_W + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] a_sr, a_sr_d, b_sr, b_sr_d;
  logic [WIDTH-1:0] sh_data, sh_data_d, res_data_q, res_data_d;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_d;
  logic [CAP_W-1:0] cap_cnt, cap_cnt_d;
  logic             sh_ovf, sh_ovf_d, res_ovf_q, res_ovf_d;
  logic             line1_q, line1_d, line2_q, line2_d;
  logic             res_valid_q, res_valid_d, busy_q, busy_d;
  logic             cap_en, cap_last, last_bit;

  // Capture starts RSP_LAT cycles into the operation and runs for WIDTH cycles.
  assign cap_en   = (state == SHIFT || state == DRAIN) &&
                    ((CMP_W'(cap_cnt) + CMP_W'(1)) > CMP_W'(RSP_LAT));
  assign cap_last = (cap_cnt == CAP_W'(WIDTH + RSP_LAT - 1));
  assign last_bit = (bit_cnt == BIT_W'(WIDTH - 1));

  always_comb begin
    state_d     = state;
    a_sr_d      = a_sr;
    b_sr_d      = b_sr;
    bit_cnt_d   = bit_cnt;
    cap_cnt_d   = cap_cnt;
    sh_data_d   = sh_data;
    sh_ovf_d    = sh_ovf;
    res_data_d  = res_data_q;
    res_ovf_d   = res_ovf_q;
    line1_d     = 1'b0;
    line2_d     = 1'b0;

    // Responses arrive in bit order, so shifting in at the MSB lands bit k at index k.
    if (cap_en) begin
      sh_data_d = {bus.outp, sh_data[WIDTH-1:1]};
      sh_ovf_d  = sh_ovf | bus.overflw;
    end

    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_d   = SHIFT;
          line1_d   = bus.in_a[0];
          line2_d   = bus.in_b[0];
          a_sr_d    = bus.in_a >> 1;
          b_sr_d    = bus.in_b >> 1;
          bit_cnt_d = '0;
          cap_cnt_d = '0;
          sh_data_d = '0;
          sh_ovf_d  = 1'b0;
        end
      end
      SHIFT: begin
        cap_cnt_d = cap_cnt + CAP_W'(1);
        if (last_bit) begin
          bit_cnt_d = '0;
          state_d   = (RSP_LAT == 0) ? DONE : DRAIN;
        end else begin
          bit_cnt_d = bit_cnt + BIT_W'(1);
          line1_d   = a_sr[0];
          line2_d   = b_sr[0];
          a_sr_d    = a_sr >> 1;
          b_sr_d    = b_sr >> 1;
        end
      end
      DRAIN: begin
        cap_cnt_d = cap_cnt + CAP_W'(1);
        if (cap_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Published result only changes when an operation completes.
    if (state_d == DONE) begin
      res_data_d = sh_data_d;
      res_ovf_d  = sh_ovf_d;
    end

    res_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      a_sr        <= '0;
      b_sr        <= '0;
      bit_cnt     <= '0;
      cap_cnt     <= '0;
      sh_data     <= '0;
      sh_ovf      <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      line1_q     <= 1'b0;
      line2_q     <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_d;
      a_sr        <= a_sr_d;
      b_sr        <= b_sr_d;
      bit_cnt     <= bit_cnt_d;
      cap_cnt     <= cap_cnt_d;
      sh_data     <= sh_data_d;
      sh_ovf      <= sh_ovf_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
      line1_q     <= line1_d;
      line2_q     <= line2_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Ready must drop in the same cycle reset is raised, so it is not registered.
  assign bus.in_ready  = (state == IDLE) & ~reset;
  assign bus.line1     = line1_q;
  assign bus.line2     = line2_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_ovf   = res_ovf_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_b01_line_tx.sv
// Bench for b01_line_tx: three instances (RSP_LAT 1, 0, 4) share one stimulus stream;
// each has a timeline model keyed on its accept edge, compared every cycle.
`timescale 1ns/1ps
module tb_b01_line_tx;
  localparam int unsigned W  = 8;
  localparam int unsigned NI = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid, s_ovf, s_outp, loop_mode;
  logic [W-1:0] s_a, s_b;
  int           n_chk = 0;
  int           n_fail = 0;
  bit           chk_en = 1'b0;

  int           got_lat  [NI];
  logic [W-1:0] got_data [NI];
  logic         got_ovf  [NI];
  logic [W-1:0] got_l1;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 4);
    b01_line_tx_if #(.WIDTH(W)) ifc ();
    logic [4:0]   pipe = '0;
    logic [5:0]   hist;
    logic         m_idle, exp_l1, exp_l2, exp_busy, exp_rv, exp_ovf;
    logic [W-1:0] exp_data;

    b01_line_tx #(.WIDTH(W), .RSP_LAT(LAT)) u_dut (
      .clock (clk),
      .reset (rst),
      .bus   (ifc)
    );

    assign ifc.in_valid = s_valid;
    assign ifc.in_a     = s_a;
    assign ifc.in_b     = s_b;
    assign ifc.overflw  = s_ovf;
    // Loopback response: line1^line2 delayed LAT cycles, else free random bits.
    assign hist         = {pipe, ifc.line1 ^ ifc.line2};
    assign ifc.outp     = loop_mode ? hist[LAT] : s_outp;
    always @(posedge clk) pipe <= {pipe[3:0], ifc.line1 ^ ifc.line2};

    // Timeline model: everything follows from the accept edge t0 and the edge count e.
    initial begin : model
      int e, t0, j, k;
      bit act;
      logic [W-1:0] ma, mb, sh, a_s, b_s;
      logic mo, v_s, r_s, o_s, f_s;
      e = 0; t0 = 0; act = 1'b0; ma = '0; mb = '0; sh = '0; mo = 1'b0;
      m_idle = 1'b1; exp_l1 = 1'b0; exp_l2 = 1'b0; exp_busy = 1'b0; exp_rv = 1'b0;
      exp_data = '0; exp_ovf = 1'b0;
      forever begin
        @(negedge clk); #4;
        v_s = s_valid; r_s = rst; o_s = ifc.outp; f_s = s_ovf; a_s = s_a; b_s = s_b;
        @(posedge clk);
        e++;
        if (r_s) begin
          act = 1'b0; exp_data = '0; exp_ovf = 1'b0;
        end else if (act) begin
          k = e - t0 - 1 - int'(LAT);
          if (k >= 0 && k < int'(W)) begin sh[k] = o_s; mo = mo | f_s; end
          if (e - t0 == int'(W + LAT)) begin exp_data = sh; exp_ovf = mo; end
          if (e - t0 > int'(W + LAT)) act = 1'b0;
        end else if (v_s) begin
          act = 1'b1; t0 = e; ma = a_s; mb = b_s; sh = '0; mo = 1'b0;
        end
        j = e + 1 - t0;
        m_idle   = !act;
        exp_busy = act;
        exp_rv   = act && (j == int'(W + LAT) + 1);
        exp_l1   = 1'b0;
        exp_l2   = 1'b0;
        if (act && j >= 1 && j <= int'(W)) begin exp_l1 = ma[j-1]; exp_l2 = mb[j-1]; end
      end
    end
  end

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t: got %h want %h", name, inst, $time, act, exp);
    end
  endtask

  task automatic chk_inst(input int i, input logic rdy, l1, l2, bz, rv, ov,
                          input logic [W-1:0] dat, input logic e_rdy, e_l1, e_l2, e_bz,
                          e_rv, e_ov, input logic [W-1:0] e_dat);
    check("in_ready", i, 32'(rdy), 32'(e_rdy));
    check("line1", i, 32'(l1), 32'(e_l1));
    check("line2", i, 32'(l2), 32'(e_l2));
    check("busy", i, 32'(bz), 32'(e_bz));
    check("res_valid", i, 32'(rv), 32'(e_rv));
    check("res_ovf", i, 32'(ov), 32'(e_ov));
    check("res_data", i, 32'(dat), 32'(e_dat));
  endtask

  initial begin : compare
    forever begin
      @(posedge clk); #2;
      if (chk_en) begin
        chk_inst(0, g_dut[0].ifc.in_ready, g_dut[0].ifc.line1, g_dut[0].ifc.line2,
                 g_dut[0].ifc.busy, g_dut[0].ifc.res_valid, g_dut[0].ifc.res_ovf,
                 g_dut[0].ifc.res_data, g_dut[0].m_idle & ~rst, g_dut[0].exp_l1,
                 g_dut[0].exp_l2, g_dut[0].exp_busy, g_dut[0].exp_rv, g_dut[0].exp_ovf,
                 g_dut[0].exp_data);
        chk_inst(1, g_dut[1].ifc.in_ready, g_dut[1].ifc.line1, g_dut[1].ifc.line2,
                 g_dut[1].ifc.busy, g_dut[1].ifc.res_valid, g_dut[1].ifc.res_ovf,
                 g_dut[1].ifc.res_data, g_dut[1].m_idle & ~rst, g_dut[1].exp_l1,
                 g_dut[1].exp_l2, g_dut[1].exp_busy, g_dut[1].exp_rv, g_dut[1].exp_ovf,
                 g_dut[1].exp_data);
        chk_inst(2, g_dut[2].ifc.in_ready, g_dut[2].ifc.line1, g_dut[2].ifc.line2,
                 g_dut[2].ifc.busy, g_dut[2].ifc.res_valid, g_dut[2].ifc.res_ovf,
                 g_dut[2].ifc.res_data, g_dut[2].m_idle & ~rst, g_dut[2].exp_l1,
                 g_dut[2].exp_l2, g_dut[2].exp_busy, g_dut[2].exp_rv, g_dut[2].exp_ovf,
                 g_dut[2].exp_data);
      end
    end
  end

  // One pulsed operation from idle; records line1 of inst0 and the first result of each inst.
  task automatic run_op(input string name, input logic [W-1:0] a, b, input int ovf_j,
                        input bit scramble, input logic [W-1:0] e_l1, e_dat,
                        input logic e_ov0, e_ov1, e_ov2);
    for (int i = 0; i < int'(NI); i++) got_lat[i] = -1;
    got_l1 = '0;
    @(negedge clk); s_valid = 1'b1; s_a = a; s_b = b;
    @(posedge clk);
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_ovf   = (j == ovf_j);
      if (scramble) s_a = W'($urandom);
      if (j <= int'(W)) got_l1[j-1] = g_dut[0].ifc.line1;
      if (got_lat[0] < 0 && g_dut[0].ifc.res_valid === 1'b1) begin
        got_lat[0] = j; got_data[0] = g_dut[0].ifc.res_data; got_ovf[0] = g_dut[0].ifc.res_ovf;
      end
      if (got_lat[1] < 0 && g_dut[1].ifc.res_valid === 1'b1) begin
        got_lat[1] = j; got_data[1] = g_dut[1].ifc.res_data; got_ovf[1] = g_dut[1].ifc.res_ovf;
      end
      if (got_lat[2] < 0 && g_dut[2].ifc.res_valid === 1'b1) begin
        got_lat[2] = j; got_data[2] = g_dut[2].ifc.res_data; got_ovf[2] = g_dut[2].ifc.res_ovf;
      end
    end
    s_ovf = 1'b0;
    check({name, "_line1_bits"}, 0, 32'(got_l1), 32'(e_l1));
    check({name, "_lat"}, 0, got_lat[0], 10);
    check({name, "_lat"}, 1, got_lat[1], 9);
    check({name, "_lat"}, 2, got_lat[2], 13);
    for (int i = 0; i < int'(NI); i++) check({name, "_data"}, i, 32'(got_data[i]), 32'(e_dat));
    check({name, "_ovf"}, 0, 32'(got_ovf[0]), 32'(e_ov0));
    check({name, "_ovf"}, 1, 32'(got_ovf[1]), 32'(e_ov1));
    check({name, "_ovf"}, 2, 32'(got_ovf[2]), 32'(e_ov2));
  endtask

  initial begin : drive
    int last0, last2, n_acc0, n_acc2, n_rv;
    rst = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; s_ovf = 1'b0; s_outp = 1'b0;
    loop_mode = 1'b1;
    repeat (3) @(posedge clk);
    #2 chk_en = 1'b1;

    @(negedge clk);
    check("rst_in_ready", 0, 32'(g_dut[0].ifc.in_ready), 32'd0);
    check("rst_busy", 0, 32'(g_dut[0].ifc.busy), 32'd0);
    check("rst_res_data", 2, 32'(g_dut[2].ifc.res_data), 32'd0);
    rst = 1'b0;
    #1 check("post_rst_in_ready", 0, 32'(g_dut[0].ifc.in_ready), 32'd1);

    run_op("a5_3c", 8'hA5, 8'h3C, 0, 1'b0, 8'hA5, 8'h99, 1'b0, 1'b0, 1'b0);
    // overflw in cycle T+9: bit-7 capture for RSP_LAT=1, outside the window for RSP_LAT=0.
    run_op("ovf_b7", 8'hA5, 8'h3C, 9, 1'b0, 8'hA5, 8'h99, 1'b1, 1'b0, 1'b1);
    run_op("zero", 8'h00, 8'h00, 0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    run_op("loop_5a", 8'h5A, 8'h00, 0, 1'b0, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0);
    run_op("scramble", 8'h96, 8'h5C, 0, 1'b1, 8'h96, 8'hCA, 1'b0, 1'b0, 1'b0);

    // Back-to-back accepts with in_valid held high.
    @(negedge clk); s_valid = 1'b1; s_a = 8'hFF; s_b = 8'h01;
    last0 = -1; last2 = -1; n_acc0 = 0; n_acc2 = 0;
    for (int c = 0; c < 60; c++) begin
      if (g_dut[0].ifc.in_ready === 1'b1) begin
        if (last0 >= 0) check("acc_gap", 0, c - last0, 11);
        last0 = c; n_acc0++;
      end
      if (g_dut[2].ifc.in_ready === 1'b1) begin
        if (last2 >= 0) check("acc_gap", 2, c - last2, 14);
        last2 = c; n_acc2++;
      end
      @(negedge clk);
    end
    check("acc_count", 0, n_acc0, 6);
    check("acc_count", 2, n_acc2, 5);
    s_valid = 1'b0;
    repeat (20) @(negedge clk);

    // Reset while bit 3 is on the line.
    s_valid = 1'b1; s_a = 8'hFF; s_b = 8'hAA;
    @(posedge clk);
    @(negedge clk); s_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_line1", 0, 32'(g_dut[0].ifc.line1), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_line1", 0, 32'(g_dut[0].ifc.line1), 32'd0);
    check("abort_line2", 2, 32'(g_dut[2].ifc.line2), 32'd0);
    check("abort_busy", 0, 32'(g_dut[0].ifc.busy), 32'd0);
    rst = 1'b0;
    n_rv = 0;
    repeat (16) begin
      @(negedge clk);
      if (g_dut[0].ifc.res_valid === 1'b1) n_rv++;
    end
    check("abort_no_res_valid", 0, n_rv, 0);
    run_op("post_abort", 8'h0F, 8'h00, 0, 1'b0, 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0);

    // Random traffic: loopback first, then free-running outp, sporadic resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      loop_mode = (c < 1500);
      s_valid   = ($urandom_range(0, 2) != 0);
      s_a       = W'($urandom);
      s_b       = W'($urandom);
      s_outp    = 1'($urandom);
      s_ovf     = ($urandom_range(0, 9) == 0);
      rst       = ($urandom_range(0, 79) == 0);
    end
    @(negedge clk); rst = 1'b0; s_valid = 1'b0; s_ovf = 1'b0;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
